fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Front end of the 8-bit core: fetches one 8-bit instruction from synchronous memory at a supplied PC, then decodes it into type, address and direction fields.
- Sits between the core control logic, which supplies the PC and fetch request and consumes the decoded fields, and the instruction/data memory port.
- Contains the fetch unit and the decode unit. The decode unit is enabled by the fetch-ready strobe.

Parameters:
- MEM_LATENCY, 1: number of clock cycles from mem_addr being registered to data_in being valid (range 1..7).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  fetch request, sampled in IDLE
- pc_in  in  8  address of instruction to fetch
- data_in  in  8  memory read data
- mem_addr  out  8  registered memory address
- pc_out  out  8  PC of the fetched instruction (see optional feature)
- inst  out  8  captured instruction word
- fetch_ready  out  1  one-cycle strobe: inst valid
- busy  out  1  high while a fetch is in flight (state != IDLE)
- inst_type  out  2  decoded inst[7:6]
- op_addr  out  6  decoded inst[5:0]
- srcdst  out  1  decoded inst[5]
- decode_ready  out  1  one-cycle strobe: decoded fields valid

Behaviour:
- Reset (rst_n low, async): every output is 0 and the FSM is in IDLE. A reset mid-fetch aborts the fetch; no ready strobe is issued for it.
- Fetch FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - fetch_en=1 at edge E0: mem_addr<=pc_in, pc_q<=pc_in, wait counter<=MEM_LATENCY, go to WAIT.
  - fetch_en=0: stay in IDLE.
- WAIT: counter decrements each edge. When it reaches 0, go to CAPTURE.
- CAPTURE edge (E0+1+MEM_LATENCY): inst<=data_in, fetch_ready<=1, pc_out updated, return to IDLE.
- fetch_ready is high for exactly one cycle. inst holds its value until the next capture.
- fetch_en is ignored outside IDLE. fetch_en high during the cycle fetch_ready is high starts a new fetch (back-to-back). Minimum period between captures is 2+MEM_LATENCY cycles.
- mem_addr holds its value between fetches.
- Decode, on the edge where fetch_ready=1:
  - inst_type<=inst[7:6], op_addr<=inst[5:0], srcdst<=inst[5], decode_ready<=1.
  - decode_ready lasts one cycle, i.e. one cycle after fetch_ready. Total latency is fetch_en edge E0 to decode_ready high after edge E0+2+MEM_LATENCY.
  - Decoded fields hold until the next decode.
- Type encoding:
  - 00: jump; op_addr is the target, zero-extended to 8 bits by the consumer.
  - 01, 10, 11: data operations; srcdst selects direction, op_addr[4:0] is the operand address.
  - All four codes are legal. Decode performs no illegal-instruction detection.

Optional Feature:
- Macro FD_PC_INC_EN.
- Defined: on the capture edge pc_out<=pc_q+1, modulo 256 (8'hFF wraps to 8'h00), giving the sequential next PC.
- Undefined: pc_out<=pc_q, the PC of the fetched instruction. The core performs any increment itself.
- The port list is identical in both builds.

Decomposition:
- Shared package fd_pkg:
  - inst_type encodings as localparams TYPE_JMP=2'b00, TYPE_OP1=2'b01, TYPE_OP2=2'b10, TYPE_OP3=2'b11.
  - Field bit positions.
  - Fetch state enum.
- Natural sub-modules: fd_fetch (FSM, address/data registers) and fd_decode (field registers, ready strobe). fetch_decode is the top that wires fetch_ready to the decode enable.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately; no fetch_ready or decode_ready after release.
- Single fetch, MEM_LATENCY=1, pc_in=8'h10, memory[0x10]=8'h3A:
  - mem_addr=8'h10 after E0, inst=8'h3A and fetch_ready after E2.
  - decode_ready after E3 with inst_type=00, op_addr=6'h3A, srcdst=1.
- Type decode: memory words 8'h45, 8'h9F, 8'hC0 -> types 01/10/11; op_addr 6'h05/6'h1F/6'h00; srcdst 0/0/0.
- Busy ignore and back-to-back: pulse fetch_en with pc_in=8'h20 during WAIT -> ignored, mem_addr unchanged. Hold fetch_en in the fetch_ready cycle with pc_in=8'h11 -> new fetch starts; captures 3 cycles apart.
- pc_out wrap: fetch at pc_in=8'hFF -> pc_out=8'h00 with FD_PC_INC_EN defined, 8'hFF without.
- MEM_LATENCY=3: fetch at 8'h05 -> fetch_ready exactly 4 edges after E0; data_in changed before that edge is not captured.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared definitions for the fetch/decode front end: instruction field layout,
// type encodings and the fetch FSM state type.
package fd_pkg;

  localparam logic [1:0] TYPE_JMP = 2'b00;
  localparam logic [1:0] TYPE_OP1 = 2'b01;
  localparam logic [1:0] TYPE_OP2 = 2'b10;
  localparam logic [1:0] TYPE_OP3 = 2'b11;

  localparam int TYPE_MSB   = 7;
  localparam int TYPE_LSB   = 6;
  localparam int ADDR_MSB   = 5;
  localparam int ADDR_LSB   = 0;
  localparam int SRCDST_BIT = 5;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } fetch_state_e;

  function automatic logic [7:0] next_pc(input logic [7:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Core/memory-facing bundle of the fetch/decode front end. The master side is the
// core plus memory model; the slave side is fetch_decode itself.
interface fetch_decode_if;
  logic       fetch_en;
  logic [7:0] pc_in;
  logic [7:0] data_in;
  logic [7:0] mem_addr;
  logic [7:0] pc_out;
  logic [7:0] inst;
  logic       fetch_ready;
  logic       busy;
  logic [1:0] inst_type;
  logic [5:0] op_addr;
  logic       srcdst;
  logic       decode_ready;

  modport master (
    output fetch_en, pc_in, data_in,
    input  mem_addr, pc_out, inst, fetch_ready, busy,
    input  inst_type, op_addr, srcdst, decode_ready
  );

  modport slave (
    input  fetch_en, pc_in, data_in,
    output mem_addr, pc_out, inst, fetch_ready, busy,
    output inst_type, op_addr, srcdst, decode_ready
  );
endinterface

// File: rtl/fd_decode.sv
// Decode unit: splits the captured instruction into type/address/direction
// fields when enabled, with a one-cycle ready strobe.
module fd_decode
  import fd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] inst,
  output logic [1:0] inst_type,
  output logic [5:0] op_addr,
  output logic       srcdst,
  output logic       decode_ready
);

  logic [1:0] inst_type_q, inst_type_d;
  logic [5:0] op_addr_q, op_addr_d;
  logic       srcdst_q, srcdst_d;
  logic       decode_ready_q, decode_ready_d;

  // All four type codes are legal; fields are sliced without validation.
  always_comb begin
    inst_type_d    = inst_type_q;
    op_addr_d      = op_addr_q;
    srcdst_d       = srcdst_q;
    decode_ready_d = en;
    if (en) begin
      inst_type_d = inst[TYPE_MSB:TYPE_LSB];
      op_addr_d   = inst[ADDR_MSB:ADDR_LSB];
      srcdst_d    = inst[SRCDST_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_type_q    <= '0;
      op_addr_q      <= '0;
      srcdst_q       <= 1'b0;
      decode_ready_q <= 1'b0;
    end else begin
      inst_type_q    <= inst_type_d;
      op_addr_q      <= op_addr_d;
      srcdst_q       <= srcdst_d;
      decode_ready_q <= decode_ready_d;
    end
  end

  assign inst_type    = inst_type_q;
  assign op_addr      = op_addr_q;
  assign srcdst       = srcdst_q;
  assign decode_ready = decode_ready_q;

endmodule

// File: rtl/fd_fetch.sv
// Fetch unit: IDLE/WAIT/CAPTURE FSM that issues an address, waits MEM_LATENCY
// cycles and captures the instruction word. FD_PC_INC_EN makes pc_out the next PC.
module fd_fetch
  import fd_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fetch_en,
  input  logic [7:0] pc_in,
  input  logic [7:0] data_in,
  output logic [7:0] mem_addr,
  output logic [7:0] pc_out,
  output logic [7:0] inst,
  output logic       fetch_ready,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LATENCY);

  fetch_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mem_addr_q, mem_addr_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       pc_out_q, pc_out_d;
  logic [7:0]       inst_q, inst_d;
  logic             fetch_ready_q, fetch_ready_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The counter still holds 1 on the edge where it decrements to 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fetch_en) state_d = ST_WAIT;
      ST_WAIT:    if (cnt_q == CNT_W'(1)) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    mem_addr_d    = mem_addr_q;
    pc_d          = pc_q;
    pc_out_d      = pc_out_q;
    inst_d        = inst_q;
    fetch_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          mem_addr_d = pc_in;
          pc_d       = pc_in;
          cnt_d      = LAT_INIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        inst_d        = data_in;
        fetch_ready_d = 1'b1;
`ifdef FD_PC_INC_EN
        pc_out_d      = next_pc(pc_q);
`else
        pc_out_d      = pc_q;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      mem_addr_q    <= '0;
      pc_q          <= '0;
      pc_out_q      <= '0;
      inst_q        <= '0;
      fetch_ready_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      mem_addr_q    <= mem_addr_d;
      pc_q          <= pc_d;
      pc_out_q      <= pc_out_d;
      inst_q        <= inst_d;
      fetch_ready_q <= fetch_ready_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign pc_out      = pc_out_q;
  assign inst        = inst_q;
  assign fetch_ready = fetch_ready_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: rtl/fetch_decode.sv
// Front end of the 8-bit core: fetch unit feeding the decode unit, whose enable
// is the fetch-ready strobe. Optional macro FD_PC_INC_EN selects pc_out = PC+1.
module fetch_decode
  import fd_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_decode_if.slave bus
);

  logic [7:0] inst_w;
  logic       fetch_ready_w;

  fd_fetch #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (bus.fetch_en),
    .pc_in       (bus.pc_in),
    .data_in     (bus.data_in),
    .mem_addr    (bus.mem_addr),
    .pc_out      (bus.pc_out),
    .inst        (inst_w),
    .fetch_ready (fetch_ready_w),
    .busy        (bus.busy)
  );

  fd_decode u_decode (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (fetch_ready_w),
    .inst         (inst_w),
    .inst_type    (bus.inst_type),
    .op_addr      (bus.op_addr),
    .srcdst       (bus.srcdst),
    .decode_ready (bus.decode_ready)
  );

  assign bus.inst        = inst_w;
  assign bus.fetch_ready = fetch_ready_w;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: lane 0 uses MEM_LATENCY=1, lane 1 MEM_LATENCY=3.
// A timestamp-based model predicts every output each cycle.
module tb_fetch_decode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_if bus0 ();
  fetch_decode_if bus1 ();

  fetch_decode #(.MEM_LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  fetch_decode #(.MEM_LATENCY(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic       fe [2];
  logic [7:0] pc [2];
  logic [7:0] din[2];

  assign bus0.fetch_en = fe[0];
  assign bus0.pc_in    = pc[0];
  assign bus0.data_in  = din[0];
  assign bus1.fetch_en = fe[1];
  assign bus1.pc_in    = pc[1];
  assign bus1.data_in  = din[1];

  logic [7:0] o_addr[2], o_pco[2], o_inst[2];
  logic       o_fr[2], o_busy[2], o_sd[2], o_dr[2];
  logic [1:0] o_type[2];
  logic [5:0] o_op[2];

  assign o_addr[0] = bus0.mem_addr;  assign o_addr[1] = bus1.mem_addr;
  assign o_pco[0]  = bus0.pc_out;    assign o_pco[1]  = bus1.pc_out;
  assign o_inst[0] = bus0.inst;      assign o_inst[1] = bus1.inst;
  assign o_fr[0]   = bus0.fetch_ready;  assign o_fr[1] = bus1.fetch_ready;
  assign o_busy[0] = bus0.busy;      assign o_busy[1] = bus1.busy;
  assign o_type[0] = bus0.inst_type; assign o_type[1] = bus1.inst_type;
  assign o_op[0]   = bus0.op_addr;   assign o_op[1]   = bus1.op_addr;
  assign o_sd[0]   = bus0.srcdst;    assign o_sd[1]   = bus1.srcdst;
  assign o_dr[0]   = bus0.decode_ready; assign o_dr[1] = bus1.decode_ready;

  logic [7:0] mem[256];

  // Reference model: a fetch issued at edge n captures at edge n+1+lat.
  logic       m_fl[2];
  int         m_iss[2];
  logic [7:0] m_pc[2];
  logic [7:0] e_addr[2], e_pco[2], e_inst[2];
  logic       e_fr[2], e_sd[2], e_dr[2];
  logic [1:0] e_type[2];
  logic [5:0] e_op[2];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_fr[2];
  int prev_fr[2];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic reset_model(input int k);
    m_fl[k] = 1'b0; m_iss[k] = 0; m_pc[k] = 8'h00;
    e_addr[k] = 8'h00; e_pco[k] = 8'h00; e_inst[k] = 8'h00;
    e_fr[k] = 1'b0; e_dr[k] = 1'b0; e_sd[k] = 1'b0;
    e_type[k] = 2'b00; e_op[k] = 6'h00;
  endtask

  task automatic model_edge(input int k);
    logic [7:0] inc;
    inc = 8'd0;
`ifdef FD_PC_INC_EN
    inc = 8'd1;
`endif
    if (!rst_n) begin
      reset_model(k);
      return;
    end
    e_dr[k] = e_fr[k];
    if (e_fr[k]) begin
      e_type[k] = e_inst[k][7:6];
      e_op[k]   = e_inst[k][5:0];
      e_sd[k]   = e_inst[k][5];
    end
    e_fr[k] = 1'b0;
    if (m_fl[k] && cyc == m_iss[k] + 1 + lat(k)) begin
      e_inst[k] = din[k];
      e_pco[k]  = m_pc[k] + inc;
      e_fr[k]   = 1'b1;
      m_fl[k]   = 1'b0;
      $display("lane%0d cyc %0d capture pc=%h inst=%h", k, cyc, m_pc[k], din[k]);
    end else if (!m_fl[k] && fe[k]) begin
      m_fl[k]   = 1'b1;
      m_iss[k]  = cyc;
      m_pc[k]   = pc[k];
      e_addr[k] = pc[k];
    end
  endtask

  task automatic check_lane(input int k);
    check($sformatf("L%0d mem_addr", k), 32'(o_addr[k]), 32'(e_addr[k]));
    check($sformatf("L%0d pc_out", k),   32'(o_pco[k]),  32'(e_pco[k]));
    check($sformatf("L%0d inst", k),     32'(o_inst[k]), 32'(e_inst[k]));
    check($sformatf("L%0d fetch_ready", k), 32'(o_fr[k]), 32'(e_fr[k]));
    check($sformatf("L%0d busy", k),     32'(o_busy[k]), 32'(m_fl[k]));
    check($sformatf("L%0d inst_type", k), 32'(o_type[k]), 32'(e_type[k]));
    check($sformatf("L%0d op_addr", k),  32'(o_op[k]),   32'(e_op[k]));
    check($sformatf("L%0d srcdst", k),   32'(o_sd[k]),   32'(e_sd[k]));
    check($sformatf("L%0d decode_ready", k), 32'(o_dr[k]), 32'(e_dr[k]));
    if (o_fr[k] === 1'b1) begin
      prev_fr[k] = last_fr[k];
      last_fr[k] = cyc;
    end
  endtask

  // Memory data is only valid in the cycle before the capture edge; random otherwise.
  task automatic tick(input logic f0, input logic [7:0] p0,
                      input logic f1, input logic [7:0] p1);
    fe[0] = f0; pc[0] = p0; fe[1] = f1; pc[1] = p1;
    for (int k = 0; k < 2; k++) begin
      if (m_fl[k] && cyc == m_iss[k] + lat(k))
        din[k] = mem[m_pc[k]];
      else
        din[k] = 8'($urandom);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_edge(k);
      check_lane(k);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  logic [1:0] x_type[3];
  logic [5:0] x_op[3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'h3A;
    mem[8'h40] = 8'h45; mem[8'h41] = 8'h9F; mem[8'h42] = 8'hC0;
    mem[8'h05] = 8'h7E;
    x_type[0] = 2'b01; x_type[1] = 2'b10; x_type[2] = 2'b11;
    x_op[0] = 6'h05;   x_op[1] = 6'h1F;   x_op[2] = 6'h00;
    for (int k = 0; k < 2; k++) begin
      reset_model(k);
      fe[k] = 1'b0; pc[k] = 8'h00; din[k] = 8'h00;
      last_fr[k] = 0; prev_fr[k] = 0;
    end

    #1;
    check_lane(0);
    check_lane(1);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Single fetch on lane 0 at 0x10.
    tick(1'b1, 8'h10, 1'b0, 8'h00);
    check("single mem_addr", 32'(o_addr[0]), 32'h10);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    check("single inst", 32'(o_inst[0]), 32'h3A);
    check("single fetch_ready", 32'(o_fr[0]), 32'h1);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    check("single decode_ready", 32'(o_dr[0]), 32'h1);
    check("single type", 32'(o_type[0]), 32'h0);
    check("single op_addr", 32'(o_op[0]), 32'h3A);
    check("single srcdst", 32'(o_sd[0]), 32'h1);
    idle(2);

    // Back-to-back type decode on lane 0.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'(8'h40 + i), 1'b0, 8'h00);
      if (i > 0) begin
        check("types type", 32'(o_type[0]), 32'(x_type[i-1]));
        check("types op_addr", 32'(o_op[0]), 32'(x_op[i-1]));
        check("types srcdst", 32'(o_sd[0]), 32'h0);
      end
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      tick(1'b0, 8'h00, 1'b0, 8'h00);
    end
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    check("types type", 32'(o_type[0]), 32'(x_type[2]));
    check("types op_addr", 32'(o_op[0]), 32'(x_op[2]));
    idle(2);

    // fetch_en ignored while busy; accepted in the fetch_ready cycle.
    tick(1'b1, 8'h30, 1'b0, 8'h00);
    tick(1'b1, 8'h20, 1'b0, 8'h00);
    check("ignore mem_addr", 32'(o_addr[0]), 32'h30);
    tick(1'b1, 8'h11, 1'b0, 8'h00);
    tick(1'b1, 8'h11, 1'b0, 8'h00);
    check("b2b mem_addr", 32'(o_addr[0]), 32'h11);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    check("b2b capture spacing", 32'(last_fr[0] - prev_fr[0]), 32'd3);
    idle(2);

    // PC wrap.
    tick(1'b1, 8'hFF, 1'b0, 8'h00);
    idle(2);
`ifdef FD_PC_INC_EN
    check("wrap pc_out", 32'(o_pco[0]), 32'h00);
`else
    check("wrap pc_out", 32'(o_pco[0]), 32'hFF);
`endif
    idle(2);

    // Lane 1, latency 3: ready exactly 4 edges after issue.
    tick(1'b0, 8'h00, 1'b1, 8'h05);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      check("lat3 early ready", 32'(o_fr[1]), 32'h0);
    end
    tick(1'b0, 8'h00, 1'b0, 8'h00);
    check("lat3 ready", 32'(o_fr[1]), 32'h1);
    check("lat3 inst", 32'(o_inst[1]), 32'h7E);
    idle(2);

    // Randomized traffic on both lanes.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 2) == 0), 8'($urandom),
           ($urandom_range(0, 2) == 0), 8'($urandom));
    end
    idle(8);

    // Asynchronous reset mid-WAIT aborts the fetch.
    tick(1'b1, 8'h50, 1'b1, 8'h51);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model(0);
    reset_model(1);
    check_lane(0);
    check_lane(1);
    tick(1'b1, 8'h60, 1'b1, 8'h61);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 8'h00, 1'b0, 8'h00);
      check("post-reset fetch_ready", 32'(o_fr[0] | o_fr[1]), 32'h0);
      check("post-reset decode_ready", 32'(o_dr[0] | o_dr[1]), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
